// File: rtl/store_unit.sv
// store_unit: SB/SH/SW execute stage with alignment checks and an in-order
// store buffer drained to data memory over a valid/ready handshake.
module store_unit #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [31:0]       Read_data1,
    input  logic [31:0]       Read_data2,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              misalign,
    output logic              bad_op,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } entry_t;

    entry_t           buf_q [DEPTH];
    entry_t           buf_d [DEPTH];
    entry_t           ent;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             run_q, misalign_q, misalign_d, bad_op_q, bad_op_d;
    logic [31:0]      ea;
    logic [5:0]       op;
    logic [1:0]       o;
    logic             is_sw, is_sh, is_sb, is_st, legal, accept, push, pop;
    logic             unused;

    assign unused = ^instruction[25:16];

    // run_q delays in_ready by one cycle after reset is released
    assign in_ready  = run_q && (count_q != CNT_W'(DEPTH));
    assign mem_valid = count_q != '0;
    assign mem_addr  = mem_valid ? buf_q[rd_ptr_q].addr : '0;
    assign mem_wdata = mem_valid ? buf_q[rd_ptr_q].wdata : '0;
    assign mem_be    = mem_valid ? buf_q[rd_ptr_q].be : '0;
    assign misalign  = misalign_q;
    assign bad_op    = bad_op_q;
    assign count     = count_q;

    always_comb begin
        op         = instruction[31:26];
        ea         = Read_data1 + {{16{instruction[15]}}, instruction[15:0]};
        o          = ea[1:0];
        is_sw      = op == 6'h2B;
        is_sh      = op == 6'h29;
        is_sb      = op == 6'h28;
        is_st      = is_sw || is_sh || is_sb;
        legal      = is_sw ? (o == 2'd0) : is_sh ? !o[0] : is_sb;
        accept     = in_valid && in_ready;
        push       = accept && legal;
        pop        = mem_valid && mem_ready;
        ent.addr   = {ea[ADDR_W-1:2], 2'b00};
        ent.be     = is_sw ? 4'hF : is_sh ? (o[1] ? 4'hC : 4'h3) : 4'b0001 << o;
        ent.wdata  = is_sw ? Read_data2 : is_sh ? {2{Read_data2[15:0]}} : {4{Read_data2[7:0]}};
        buf_d      = buf_q;
        if (push) buf_d[wr_ptr_q] = ent;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        misalign_d = accept && is_st && !legal;
        bad_op_d   = accept && !is_st;
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (!reset) begin
            run_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            bad_op_q   <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            bad_op_q   <= bad_op_d;
        end
    end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed vectors with hand-computed expectations for store_unit.
module tb_store_unit;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, mem_valid, mem_ready, misalign, bad_op;
    logic [31:0] instruction, Read_data1, Read_data2, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;
    int          total = 0;
    int          bad = 0;

    store_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .Read_data1(Read_data1), .Read_data2(Read_data2),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .misalign(misalign), .bad_op(bad_op),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] base, input logic [15:0] imm, input logic [31:0] rt);
        in_valid    = 1'b1;
        instruction = {op, 10'd0, imm};
        Read_data1  = base;
        Read_data2  = rt;
    endtask

    task automatic head(input string tag, input logic [31:0] a, input logic [31:0] w, input logic [3:0] b, input logic [2:0] c);
        check({tag, ".valid"}, 32'(mem_valid), 32'(c != 0));
        check({tag, ".addr"}, mem_addr, a);
        check({tag, ".wdata"}, mem_wdata, w);
        check({tag, ".be"}, 32'(mem_be), 32'(b));
        check({tag, ".count"}, 32'(count), 32'(c));
    endtask

    initial begin
        reset = 1'b0;
        mem_ready = 1'b1;
        issue(6'h2B, 32'h1000, 16'h0000, 32'h11111111);
        tick();
        tick();
        head("rst", 32'h0, 32'h0, 4'h0, 3'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.misalign", 32'(misalign), 32'd0);
        check("rst.bad_op", 32'(bad_op), 32'd0);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel.in_ready_pre", 32'(in_ready), 32'd0);
        tick();
        check("rel.in_ready", 32'(in_ready), 32'd1);
        head("rel", 32'h0, 32'h0, 4'h0, 3'd0);

        issue(6'h2B, 32'h1000, 16'hFFFC, 32'hDEADBEEF);
        tick();
        in_valid = 1'b0;
        head("sw", 32'h0FFC, 32'hDEADBEEF, 4'hF, 3'd1);
        tick();
        head("sw.pop", 32'h0, 32'h0, 4'h0, 3'd0);

        mem_ready = 1'b0;
        issue(6'h28, 32'h2000, 16'h0003, 32'h000000A5);
        tick();
        in_valid = 1'b0;
        head("sb", 32'h2000, 32'hA5A5A5A5, 4'h8, 3'd1);
        tick();
        head("sb.hold", 32'h2000, 32'hA5A5A5A5, 4'h8, 3'd1);
        mem_ready = 1'b1;
        issue(6'h29, 32'h2000, 16'h0002, 32'h00001234);
        tick();
        in_valid = 1'b0;
        head("sh", 32'h2000, 32'h12341234, 4'hC, 3'd1);
        tick();
        head("sh.pop", 32'h0, 32'h0, 4'h0, 3'd0);

        issue(6'h2B, 32'h2000, 16'h0002, 32'h55555555);
        tick();
        in_valid = 1'b0;
        check("mis.pulse", 32'(misalign), 32'd1);
        check("mis.bad_op", 32'(bad_op), 32'd0);
        head("mis", 32'h0, 32'h0, 4'h0, 3'd0);
        tick();
        check("mis.low", 32'(misalign), 32'd0);
        issue(6'h23, 32'h2000, 16'h0002, 32'h55555555);
        tick();
        in_valid = 1'b0;
        check("bop.pulse", 32'(bad_op), 32'd1);
        check("bop.misalign", 32'(misalign), 32'd0);
        head("bop", 32'h0, 32'h0, 4'h0, 3'd0);
        tick();
        check("bop.low", 32'(bad_op), 32'd0);

        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(6'h2B, 32'(i * 4), 16'h0000, 32'hA0 + 32'(i));
            tick();
        end
        issue(6'h2B, 32'h10, 16'h0000, 32'hA4);
        check("bp.in_ready", 32'(in_ready), 32'd0);
        head("bp.full", 32'h0, 32'hA0, 4'hF, 3'd4);
        tick();
        head("bp.hold", 32'h0, 32'hA0, 4'hF, 3'd4);
        mem_ready = 1'b1;
        tick();
        head("bp.pop0", 32'h4, 32'hA1, 4'hF, 3'd3);
        check("bp.ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        head("bp.pop1", 32'h8, 32'hA2, 4'hF, 3'd3);
        tick();
        head("bp.pop2", 32'hC, 32'hA3, 4'hF, 3'd2);
        tick();
        head("bp.pop3", 32'h10, 32'hA4, 4'hF, 3'd1);
        tick();
        head("bp.empty", 32'h0, 32'h0, 4'h0, 3'd0);

        mem_ready = 1'b0;
        issue(6'h2B, 32'h100, 16'h0000, 32'hB0);
        tick();
        issue(6'h2B, 32'h104, 16'h0000, 32'hB1);
        tick();
        head("sim.two", 32'h100, 32'hB0, 4'hF, 3'd2);
        mem_ready = 1'b1;
        issue(6'h2B, 32'h108, 16'h0000, 32'hB2);
        tick();
        in_valid = 1'b0;
        mem_ready = 1'b0;
        head("sim.pushpop", 32'h104, 32'hB1, 4'hF, 3'd2);
        tick();
        head("sim.held", 32'h104, 32'hB1, 4'hF, 3'd2);
        reset = 1'b0;
        tick();
        head("mid.rst", 32'h0, 32'h0, 4'h0, 3'd0);
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        head("mid.after", 32'h0, 32'h0, 4'h0, 3'd0);
        check("mid.in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
